// File: rtl/exstage.sv
// ----------------------------------------------------------------------------
// exstage: execute stage of a 5-stage RV32 pipeline.
//
// Resolves operand forwarding (EX/MEM first, then WB) and the load-use hazard.
// It computes the ALU result, the branch/jump target and the redirect, and
// registers the EX/MEM pipeline entry.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-low reset
//   stall_i, flush_i         hold / kill the EX/MEM register
//   id_valid_i + operands    ID/EX entry (pc, rs data, imm, indices, controls)
//   wb_*                     writeback forwarding source
//   *_o (registered)         EX/MEM entry consumed by the memory stage
//   redirect_o/_pc_o         combinational control-flow redirect
//   hazard_o                 combinational load-use stall request
// ----------------------------------------------------------------------------
module exstage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        id_valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   input  logic [4:0]  rd_addr_i,
   input  logic [3:0]  alu_op_i,
   input  logic        alu_src_a_i,
   input  logic        alu_src_b_i,
   input  logic        regwrite_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   input  logic        branch_i,
   input  logic        jal_i,
   input  logic        jalr_i,
   input  logic [1:0]  memtoreg_i,
   input  logic [2:0]  funct3_i,
   input  logic        wb_regwrite_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic        regwrite_o,
   output logic [4:0]  rd_addr_o,
   output logic [1:0]  memtoreg_o,
   output logic [31:0] pc_address_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] store_data_o,
   output logic        memread_o,
   output logic        memwrite_o,
   output logic [2:0]  funct3_o,
   output logic        ex_valid_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        hazard_o
);

   localparam logic [3:0] OpAdd   = 4'd0;
   localparam logic [3:0] OpSub   = 4'd1;
   localparam logic [3:0] OpSll   = 4'd2;
   localparam logic [3:0] OpSlt   = 4'd3;
   localparam logic [3:0] OpSltu  = 4'd4;
   localparam logic [3:0] OpXor   = 4'd5;
   localparam logic [3:0] OpSrl   = 4'd6;
   localparam logic [3:0] OpSra   = 4'd7;
   localparam logic [3:0] OpOr    = 4'd8;
   localparam logic [3:0] OpAnd   = 4'd9;
   localparam logic [3:0] OpPassB = 4'd10;

   logic        regwrite_q, regwrite_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [1:0]  memtoreg_q, memtoreg_d;
   logic [31:0] pc_address_q, pc_address_d;
   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] store_data_q, store_data_d;
   logic        memread_q, memread_d;
   logic        memwrite_q, memwrite_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        ex_valid_q, ex_valid_d;

   logic [31:0] rs1_fwd, rs2_fwd;
   logic [31:0] op_a, op_b, alu_res;
   logic [4:0]  shamt;
   logic        taken;
   logic [31:0] jalr_sum, target;
   logic        hazard, go;

   // A load in EX/MEM has no data yet, so it never forwards; hazard covers it.
   logic ex_fwd_ok;
   assign ex_fwd_ok = ex_valid_q & regwrite_q & ~memread_q;

   always_comb begin
      rs1_fwd = rs1_data_i;
      if (rs1_addr_i != 5'd0) begin
         if (ex_fwd_ok && (rd_addr_q == rs1_addr_i)) begin
            rs1_fwd = alu_result_q;
         end else if (wb_regwrite_i && (wb_rd_i == rs1_addr_i)) begin
            rs1_fwd = wb_data_i;
         end
      end
   end

   always_comb begin
      rs2_fwd = rs2_data_i;
      if (rs2_addr_i != 5'd0) begin
         if (ex_fwd_ok && (rd_addr_q == rs2_addr_i)) begin
            rs2_fwd = alu_result_q;
         end else if (wb_regwrite_i && (wb_rd_i == rs2_addr_i)) begin
            rs2_fwd = wb_data_i;
         end
      end
   end

   assign hazard = rst_i & id_valid_i & ex_valid_q & memread_q & (rd_addr_q != 5'd0) &
                   ((rd_addr_q == rs1_addr_i) | (rd_addr_q == rs2_addr_i));
   assign hazard_o = hazard;

   assign op_a  = alu_src_a_i ? pc_i : rs1_fwd;
   assign op_b  = alu_src_b_i ? imm_i : rs2_fwd;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = 32'd0;
      case (alu_op_i)
         OpAdd:   alu_res = op_a + op_b;
         OpSub:   alu_res = op_a - op_b;
         OpSll:   alu_res = op_a << shamt;
         OpSlt:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         OpSltu:  alu_res = {31'd0, op_a < op_b};
         OpXor:   alu_res = op_a ^ op_b;
         OpSrl:   alu_res = op_a >> shamt;
         OpSra:   alu_res = $unsigned($signed(op_a) >>> shamt);
         OpOr:    alu_res = op_a | op_b;
         OpAnd:   alu_res = op_a & op_b;
         OpPassB: alu_res = op_b;
         default: alu_res = 32'd0;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3_i)
         3'b000:  taken = (rs1_fwd == rs2_fwd);
         3'b001:  taken = (rs1_fwd != rs2_fwd);
         3'b100:  taken = ($signed(rs1_fwd) < $signed(rs2_fwd));
         3'b101:  taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
         3'b110:  taken = (rs1_fwd < rs2_fwd);
         3'b111:  taken = (rs1_fwd >= rs2_fwd);
         default: taken = 1'b0;
      endcase
   end

   assign jalr_sum = rs1_fwd + imm_i;
   assign target   = jalr_i ? {jalr_sum[31:1], 1'b0} : (pc_i + imm_i);

   // rst_i gating keeps redirect quiet while the pipeline is held in reset.
   assign go            = rst_i & id_valid_i & ~hazard & ~stall_i & ~flush_i;
   assign redirect_o    = go & (jal_i | jalr_i | (branch_i & taken));
   assign redirect_pc_o = target;

   always_comb begin
      regwrite_d   = regwrite_q;
      rd_addr_d    = rd_addr_q;
      memtoreg_d   = memtoreg_q;
      pc_address_d = pc_address_q;
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      memread_d    = memread_q;
      memwrite_d   = memwrite_q;
      funct3_d     = funct3_q;
      ex_valid_d   = ex_valid_q;
      if (flush_i || (!stall_i && hazard)) begin
         // Kill or bubble: only the control bits need clearing.
         ex_valid_d = 1'b0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
      end else if (!stall_i) begin
         ex_valid_d   = id_valid_i;
         regwrite_d   = id_valid_i & regwrite_i & (rd_addr_i != 5'd0);
         memread_d    = id_valid_i & memread_i;
         memwrite_d   = id_valid_i & memwrite_i;
         rd_addr_d    = rd_addr_i;
         memtoreg_d   = memtoreg_i;
         pc_address_d = pc_i;
         alu_result_d = alu_res;
         store_data_d = rs2_fwd;
         funct3_d     = funct3_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         regwrite_q   <= 1'b0;
         rd_addr_q    <= 5'd0;
         memtoreg_q   <= 2'd0;
         pc_address_q <= 32'd0;
         alu_result_q <= 32'd0;
         store_data_q <= 32'd0;
         memread_q    <= 1'b0;
         memwrite_q   <= 1'b0;
         funct3_q     <= 3'd0;
         ex_valid_q   <= 1'b0;
      end else begin
         regwrite_q   <= regwrite_d;
         rd_addr_q    <= rd_addr_d;
         memtoreg_q   <= memtoreg_d;
         pc_address_q <= pc_address_d;
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         memread_q    <= memread_d;
         memwrite_q   <= memwrite_d;
         funct3_q     <= funct3_d;
         ex_valid_q   <= ex_valid_d;
      end
   end

   assign regwrite_o   = regwrite_q;
   assign rd_addr_o    = rd_addr_q;
   assign memtoreg_o   = memtoreg_q;
   assign pc_address_o = pc_address_q;
   assign alu_result_o = alu_result_q;
   assign store_data_o = store_data_q;
   assign memread_o    = memread_q;
   assign memwrite_o   = memwrite_q;
   assign funct3_o     = funct3_q;
   assign ex_valid_o   = ex_valid_q;

endmodule

// File: tb/tb_exstage.sv
// ----------------------------------------------------------------------------
// tb_exstage: directed self-checking bench for exstage.
// Inputs change 1 time unit after a rising edge; registered outputs are
// sampled 1 unit after the edge that loads them, combinational ones before
// the next edge.
// ----------------------------------------------------------------------------
module tb_exstage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, id_valid;
   logic [31:0] pc, rs1_data, rs2_data, imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [3:0]  alu_op;
   logic        src_a, src_b, regwrite, memread, memwrite, branch, jal, jalr;
   logic [1:0]  memtoreg;
   logic [2:0]  funct3;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic        regwrite_o, memread_o, memwrite_o, ex_valid_o, redirect_o, hazard_o;
   logic [4:0]  rd_addr_o;
   logic [1:0]  memtoreg_o;
   logic [2:0]  funct3_o;
   logic [31:0] pc_address_o, alu_result_o, store_data_o, redirect_pc_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   exstage dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .flush_i       (flush),
      .id_valid_i    (id_valid),
      .pc_i          (pc),
      .rs1_data_i    (rs1_data),
      .rs2_data_i    (rs2_data),
      .imm_i         (imm),
      .rs1_addr_i    (rs1_addr),
      .rs2_addr_i    (rs2_addr),
      .rd_addr_i     (rd_addr),
      .alu_op_i      (alu_op),
      .alu_src_a_i   (src_a),
      .alu_src_b_i   (src_b),
      .regwrite_i    (regwrite),
      .memread_i     (memread),
      .memwrite_i    (memwrite),
      .branch_i      (branch),
      .jal_i         (jal),
      .jalr_i        (jalr),
      .memtoreg_i    (memtoreg),
      .funct3_i      (funct3),
      .wb_regwrite_i (wb_regwrite),
      .wb_rd_i       (wb_rd),
      .wb_data_i     (wb_data),
      .regwrite_o    (regwrite_o),
      .rd_addr_o     (rd_addr_o),
      .memtoreg_o    (memtoreg_o),
      .pc_address_o  (pc_address_o),
      .alu_result_o  (alu_result_o),
      .store_data_o  (store_data_o),
      .memread_o     (memread_o),
      .memwrite_o    (memwrite_o),
      .funct3_o      (funct3_o),
      .ex_valid_o    (ex_valid_o),
      .redirect_o    (redirect_o),
      .redirect_pc_o (redirect_pc_o),
      .hazard_o      (hazard_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain valid R-type ADD with no forwarding sources active.
   task automatic idle_inputs();
      stall = 0; flush = 0; id_valid = 1; pc = 32'h0;
      rs1_data = 0; rs2_data = 0; imm = 0;
      rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
      alu_op = 4'd0; src_a = 0; src_b = 0;
      regwrite = 0; memread = 0; memwrite = 0; branch = 0; jal = 0; jalr = 0;
      memtoreg = 2'd0; funct3 = 3'd0;
      wb_regwrite = 0; wb_rd = 0; wb_data = 0;
   endtask

   task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      idle_inputs();
      alu_op = op; rs1_data = a; rs2_data = b; rd_addr = 5'd9; regwrite = 1;
      tick();
      check_eq(tag, alu_result_o, exp);
   endtask

   initial begin
      idle_inputs();
      // Reset held with stall and a jump presented.
      rst = 0; stall = 1; jal = 1;
      #1;
      check_eq("redirect_in_reset", 32'(redirect_o), 32'd0);
      check_eq("hazard_in_reset", 32'(hazard_o), 32'd0);
      tick(); tick();
      check_eq("rst_ex_valid", 32'(ex_valid_o), 32'd0);
      check_eq("rst_alu", alu_result_o, 32'd0);
      check_eq("rst_regwrite", 32'(regwrite_o), 32'd0);
      check_eq("rst_pc_addr", pc_address_o, 32'd0);
      rst = 1;

      // ADD x5 = 5 + 7
      idle_inputs();
      rs1_data = 5; rs2_data = 7; rd_addr = 5; regwrite = 1; pc = 32'h40;
      tick();
      check_eq("add_result", alu_result_o, 32'd12);
      check_eq("add_valid", 32'(ex_valid_o), 32'd1);
      check_eq("add_regwrite", 32'(regwrite_o), 32'd1);
      check_eq("add_rd", 32'(rd_addr_o), 32'd5);
      check_eq("add_pc_addr", pc_address_o, 32'h40);

      // ADDI x1 = x0 + 1, then ADD x2 = x1 + x1 with stale register data.
      idle_inputs();
      imm = 1; src_b = 1; rd_addr = 1; regwrite = 1;
      tick();
      check_eq("addi_result", alu_result_o, 32'd1);
      idle_inputs();
      rs1_addr = 1; rs2_addr = 1; rd_addr = 2; regwrite = 1;
      tick();
      check_eq("fwd_exmem", alu_result_o, 32'd2);
      check_eq("fwd_store_data", store_data_o, 32'd1);

      // EX/MEM holds x2 now; only WB has x1 = 9.
      idle_inputs();
      rs1_addr = 1; rs2_addr = 1; rd_addr = 3; regwrite = 1;
      wb_regwrite = 1; wb_rd = 1; wb_data = 9;
      tick();
      check_eq("fwd_wb", alu_result_o, 32'd18);

      // EX/MEM x3 = 18 beats WB x3 = 100; x0 never forwards from WB.
      idle_inputs();
      rs1_addr = 3; rs2_addr = 0; rs2_data = 5; rd_addr = 4; regwrite = 1;
      wb_regwrite = 1; wb_rd = 3; wb_data = 100;
      tick();
      check_eq("fwd_priority_x0", alu_result_o, 32'd23);

      // rd = x0 never writes.
      idle_inputs();
      rd_addr = 0; regwrite = 1; rs1_data = 1;
      tick();
      check_eq("rd0_regwrite", 32'(regwrite_o), 32'd0);
      check_eq("rd0_valid", 32'(ex_valid_o), 32'd1);

      // LW x3, 4(x0) then a dependent op (also flagged as jal).
      idle_inputs();
      imm = 4; src_b = 1; rd_addr = 3; regwrite = 1; memread = 1; memtoreg = 2'd1;
      funct3 = 3'b010;
      tick();
      check_eq("lw_memread", 32'(memread_o), 32'd1);
      check_eq("lw_memtoreg", 32'(memtoreg_o), 32'd1);
      check_eq("lw_funct3", 32'(funct3_o), 32'd2);
      idle_inputs();
      rs1_addr = 3; rd_addr = 6; regwrite = 1; jal = 1;
      #1;
      check_eq("lu_hazard", 32'(hazard_o), 32'd1);
      check_eq("lu_no_redirect", 32'(redirect_o), 32'd0);
      tick();
      check_eq("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
      check_eq("lu_bubble_regwrite", 32'(regwrite_o), 32'd0);
      check_eq("lu_hazard_clears", 32'(hazard_o), 32'd0);

      // Branches (combinational only; EX/MEM holds a bubble, no forwarding).
      idle_inputs();
      branch = 1; pc = 32'h100; imm = 32'h20; rs1_addr = 6; rs2_addr = 7;
      rs1_data = 4; rs2_data = 4; funct3 = 3'b000;
      #1;
      check_eq("beq_redirect", 32'(redirect_o), 32'd1);
      check_eq("beq_target", redirect_pc_o, 32'h120);
      funct3 = 3'b001; #1;
      check_eq("bne_not_taken", 32'(redirect_o), 32'd0);
      rs1_data = 32'hFFFF_FFFF; rs2_data = 1; funct3 = 3'b100; #1;
      check_eq("blt_taken", 32'(redirect_o), 32'd1);
      funct3 = 3'b110; #1;
      check_eq("bltu_not_taken", 32'(redirect_o), 32'd0);
      funct3 = 3'b010; #1;
      check_eq("f3_010_not_taken", 32'(redirect_o), 32'd0);
      idle_inputs();
      jalr = 1; rs1_addr = 8; rs1_data = 32'h203; imm = 0; pc = 32'h500;
      #1;
      check_eq("jalr_redirect", 32'(redirect_o), 32'd1);
      check_eq("jalr_target", redirect_pc_o, 32'h202);

      // ALU op sweep.
      run_alu("alu_sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
      run_alu("alu_sll", 4'd2, 32'd1, 32'd33, 32'd2);
      run_alu("alu_slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
      run_alu("alu_sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
      run_alu("alu_xor", 4'd5, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
      run_alu("alu_srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
      run_alu("alu_sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
      run_alu("alu_or", 4'd8, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
      run_alu("alu_and", 4'd9, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030);
      run_alu("alu_pass_b", 4'd10, 32'd5, 32'd7, 32'd7);
      run_alu("alu_undef", 4'd15, 32'd5, 32'd7, 32'd0);

      // Stall + flush together kills the entry.
      idle_inputs();
      rs1_data = 5; rs2_data = 7; rd_addr = 5; regwrite = 1;
      tick();
      stall = 1; flush = 1;
      tick();
      check_eq("stall_flush_valid", 32'(ex_valid_o), 32'd0);

      // Stall alone holds for 3 cycles.
      idle_inputs();
      rs1_data = 5; rs2_data = 7; rd_addr = 5; regwrite = 1;
      tick();
      check_eq("pre_stall_result", alu_result_o, 32'd12);
      stall = 1; rs1_data = 100; rd_addr = 9; jal = 1;
      #1;
      check_eq("stall_no_redirect", 32'(redirect_o), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      check_eq("stall_hold_result", alu_result_o, 32'd12);
      check_eq("stall_hold_valid", 32'(ex_valid_o), 32'd1);
      check_eq("stall_hold_rd", 32'(rd_addr_o), 32'd5);
      check_eq("stall_hold_regwrite", 32'(regwrite_o), 32'd1);

      // Reset asserted mid-stall.
      rst = 0;
      tick();
      check_eq("rst_stall_valid", 32'(ex_valid_o), 32'd0);
      check_eq("rst_stall_result", alu_result_o, 32'd0);
      check_eq("rst_stall_store", store_data_o, 32'd0);
      check_eq("rst_stall_regwrite", 32'(regwrite_o), 32'd0);
      rst = 1;
      stall = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
